dly_sel_dcoder: RTL and testbench

Address decoder that steers one 3-bit delay-control command (load, adjust, inc/dec) to exactly one of 20 per-lane delay-line control buses. It sits between the fabric-side delay-control interface and the array of 20 I/O delay elements. Outputs are registered so the delay elements always see glitch-free control buses.

---
 rtl/dly_ctrl_pkg.sv | 15 +
 rtl/dly_ctrl_reg.sv | 28 ++
 rtl/dly_sel_dcoder.sv | 83 ++++++++
 tb/tb_dly_sel_dcoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dly_ctrl_pkg.sv
// Shared constants and types for the delay-line control decoder.
// Bundles the lane count, bus widths and control-bit positions.
package dly_ctrl_pkg;

  localparam int DLY_NUM_LANES = 20;
  localparam int DLY_ADDR_W    = 5;
  localparam int DLY_CTRL_W    = 3;

  localparam int DLY_CTRL_LOAD   = 2;
  localparam int DLY_CTRL_ADJ    = 1;
  localparam int DLY_CTRL_INCDEC = 0;

  typedef logic [DLY_CTRL_W-1:0] dly_ctrl_t;

endpackage

// File: rtl/dly_ctrl_reg.sv
// One lane's registered control bus.
// It holds the command while selected and zero otherwise.
module dly_ctrl_reg
  import dly_ctrl_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      sel_i,
  input  dly_ctrl_t cmd_i,
  output dly_ctrl_t ctrl_o
);

  dly_ctrl_t ctrl_d;
  dly_ctrl_t ctrl_q;

  always_comb begin
    ctrl_d = '0;
    if (sel_i) ctrl_d = cmd_i;
  end

  always_ff @(posedge CLK) begin
    if (RST) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/dly_sel_dcoder.sv
// Steers one delay command to one of 20 registered lane buses.
// Addresses 20..31 select no lane, so every bus clears.
module dly_sel_dcoder
  import dly_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       DLY_LOAD,
  input  logic       DLY_ADJ,
  input  logic       DLY_INCDEC,
  input  logic [4:0] DLY_ADDR,
  output logic [2:0] DLY0_CNTRL,
  output logic [2:0] DLY1_CNTRL,
  output logic [2:0] DLY2_CNTRL,
  output logic [2:0] DLY3_CNTRL,
  output logic [2:0] DLY4_CNTRL,
  output logic [2:0] DLY5_CNTRL,
  output logic [2:0] DLY6_CNTRL,
  output logic [2:0] DLY7_CNTRL,
  output logic [2:0] DLY8_CNTRL,
  output logic [2:0] DLY9_CNTRL,
  output logic [2:0] DLY10_CNTRL,
  output logic [2:0] DLY11_CNTRL,
  output logic [2:0] DLY12_CNTRL,
  output logic [2:0] DLY13_CNTRL,
  output logic [2:0] DLY14_CNTRL,
  output logic [2:0] DLY15_CNTRL,
  output logic [2:0] DLY16_CNTRL,
  output logic [2:0] DLY17_CNTRL,
  output logic [2:0] DLY18_CNTRL,
  output logic [2:0] DLY19_CNTRL
);

  dly_ctrl_t                 cmd;
  logic [DLY_NUM_LANES-1:0]  sel;
  dly_ctrl_t                 ctrl [DLY_NUM_LANES];

  always_comb begin
    cmd                  = '0;
    cmd[DLY_CTRL_LOAD]   = DLY_LOAD;
    cmd[DLY_CTRL_ADJ]    = DLY_ADJ;
    cmd[DLY_CTRL_INCDEC] = DLY_INCDEC;
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < DLY_NUM_LANES; i++) begin
      sel[i] = (DLY_ADDR == DLY_ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < DLY_NUM_LANES; g++) begin : g_lane
    dly_ctrl_reg u_reg (
      .CLK    (CLK),
      .RST    (RST),
      .sel_i  (sel[g]),
      .cmd_i  (cmd),
      .ctrl_o (ctrl[g])
    );
  end

  assign DLY0_CNTRL  = ctrl[0];
  assign DLY1_CNTRL  = ctrl[1];
  assign DLY2_CNTRL  = ctrl[2];
  assign DLY3_CNTRL  = ctrl[3];
  assign DLY4_CNTRL  = ctrl[4];
  assign DLY5_CNTRL  = ctrl[5];
  assign DLY6_CNTRL  = ctrl[6];
  assign DLY7_CNTRL  = ctrl[7];
  assign DLY8_CNTRL  = ctrl[8];
  assign DLY9_CNTRL  = ctrl[9];
  assign DLY10_CNTRL = ctrl[10];
  assign DLY11_CNTRL = ctrl[11];
  assign DLY12_CNTRL = ctrl[12];
  assign DLY13_CNTRL = ctrl[13];
  assign DLY14_CNTRL = ctrl[14];
  assign DLY15_CNTRL = ctrl[15];
  assign DLY16_CNTRL = ctrl[16];
  assign DLY17_CNTRL = ctrl[17];
  assign DLY18_CNTRL = ctrl[18];
  assign DLY19_CNTRL = ctrl[19];

endmodule

// File: tb/tb_dly_sel_dcoder.sv
// Bench for dly_sel_dcoder: a per-cycle lane model plus
// hand-computed expectations on directed and random vectors.
module tb_dly_sel_dcoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       DLY_LOAD = 1'b0;
  logic       DLY_ADJ = 1'b0;
  logic       DLY_INCDEC = 1'b0;
  logic [4:0] DLY_ADDR = 5'd0;
  logic [2:0] o [20];

  logic [2:0] exp_q [20];
  logic       mv = 1'b0;
  int         checks = 0;
  int         passes = 0;

  always #5 CLK = ~CLK;

  dly_sel_dcoder dut (
    .CLK(CLK), .RST(RST),
    .DLY_LOAD(DLY_LOAD), .DLY_ADJ(DLY_ADJ),
    .DLY_INCDEC(DLY_INCDEC), .DLY_ADDR(DLY_ADDR),
    .DLY0_CNTRL(o[0]),   .DLY1_CNTRL(o[1]),
    .DLY2_CNTRL(o[2]),   .DLY3_CNTRL(o[3]),
    .DLY4_CNTRL(o[4]),   .DLY5_CNTRL(o[5]),
    .DLY6_CNTRL(o[6]),   .DLY7_CNTRL(o[7]),
    .DLY8_CNTRL(o[8]),   .DLY9_CNTRL(o[9]),
    .DLY10_CNTRL(o[10]), .DLY11_CNTRL(o[11]),
    .DLY12_CNTRL(o[12]), .DLY13_CNTRL(o[13]),
    .DLY14_CNTRL(o[14]), .DLY15_CNTRL(o[15]),
    .DLY16_CNTRL(o[16]), .DLY17_CNTRL(o[17]),
    .DLY18_CNTRL(o[18]), .DLY19_CNTRL(o[19])
  );

  // Model: each lane shows last cycle's command only if it was addressed.
  always @(posedge CLK) begin
    for (int i = 0; i < 20; i++) begin
      if (!RST && int'(DLY_ADDR) == i)
        exp_q[i] <= {DLY_LOAD, DLY_ADJ, DLY_INCDEC};
      else
        exp_q[i] <= 3'b000;
    end
    mv <= 1'b1;
  end

  always @(negedge CLK) begin
    if (mv) begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (o[i] === exp_q[i]) passes++;
        else $display("FAIL model lane%0d: got %b want %b at %0t",
                      i, o[i], exp_q[i], $time);
      end
    end
  end

  task automatic step(input logic r, input logic [2:0] c,
                      input logic [4:0] a);
    RST = r;
    {DLY_LOAD, DLY_ADJ, DLY_INCDEC} = c;
    DLY_ADDR = a;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_lane(input string nm, input int lane,
                          input logic [2:0] want);
    checks++;
    if (o[lane] === want) passes++;
    else $display("FAIL %s: lane%0d got %b want %b",
                  nm, lane, o[lane], want);
  endtask

  task automatic chk_others_zero(input string nm, input int keep);
    int nz;
    nz = 0;
    for (int i = 0; i < 20; i++)
      if (i != keep && o[i] !== 3'b000) nz++;
    checks++;
    if (nz == 0) passes++;
    else $display("FAIL %s: %0d nonzero lanes, want 0", nm, nz);
  endtask

  initial begin
    logic [2:0] rc;
    logic [4:0] ra;
    @(posedge CLK);
    #1;
    step(1'b1, 3'b111, 5'd3);
    chk_others_zero("reset_a", -1);
    step(1'b1, 3'b111, 5'd3);
    chk_others_zero("reset_b", -1);
    step(1'b0, 3'b111, 5'd3);
    chk_lane("post_reset", 3, 3'b111);
    chk_others_zero("post_reset_others", 3);

    for (int a = 0; a < 20; a++) begin
      step(1'b0, 3'b101, 5'(a));
      chk_lane("sweep", a, 3'b101);
      chk_others_zero("sweep_others", a);
    end

    for (int c = 0; c < 8; c++) begin
      step(1'b0, 3'(c), 5'd19);
      chk_lane("cmd19", 19, 3'(c));
      chk_others_zero("cmd19_others", 19);
    end

    step(1'b0, 3'b111, 5'd20);
    chk_others_zero("oor20", -1);
    step(1'b0, 3'b111, 5'd25);
    chk_others_zero("oor25", -1);
    step(1'b0, 3'b111, 5'd31);
    chk_others_zero("oor31", -1);

    step(1'b0, 3'b011, 5'd0);
    chk_lane("b2b_first", 0, 3'b011);
    step(1'b0, 3'b011, 5'd1);
    chk_lane("b2b_lane0", 0, 3'b000);
    chk_lane("b2b_lane1", 1, 3'b011);

    step(1'b0, 3'b110, 5'd7);
    step(1'b0, 3'b110, 5'd7);
    chk_lane("hold", 7, 3'b110);
    step(1'b1, 3'b110, 5'd7);
    chk_lane("reset_prio", 7, 3'b000);

    for (int k = 0; k < 100; k++) begin
      rc = 3'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 31));
      step(1'b0, rc, ra);
      if (ra < 5'd20) begin
        chk_lane("rand", int'(ra), rc);
        chk_others_zero("rand_others", int'(ra));
      end else begin
        chk_others_zero("rand_oor", -1);
      end
    end

    @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
